// File: rtl/word_uart_tx.sv
// rtl/word_uart_tx.sv - 32-bit word serializer over 8N1 UART, four bytes MSB-first
module word_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] data_out_32,
    input  logic        data_rdy,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdy_q;
    logic          req;
    logic          bit_end;

    assign req     = data_rdy & ~rdy_q;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = START;
                    shift_d = data_out_32;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                // bit index wraps 7->0 on the way into STOP
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                        byte_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so the line moves on the same edge as the FSM
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[{~byte_d, bit_d}];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= data_rdy;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule
